// File: rtl/wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_arbiter_if
// Purpose : bundles the write-back arbiter's pipeline-facing inputs and its
//           register-file-facing outputs so they travel as one port.
// Signals :
//   stall, flush                      - WB bubble requests (flush dominates)
//   mem_we1/mem_waddr1/mem_wdata1     - slot-1 (older) result from MEM/WB
//   mem_we2/mem_waddr2/mem_wdata2     - slot-2 (younger) result from MEM/WB
//   lr_valid/lr_waddr/lr_wdata        - late result offer (divider, miss load)
//   lr_ready                          - late-result buffer can accept
//   we1/waddr1/wdata1                 - regfile write port 1
//   we2/waddr2/wdata2                 - regfile write port 2 (wins same-address)
//   lr_pending                        - occupied late-result entries (0..2)
// Modports: slave = arbiter side, master = pipeline/regfile/testbench side.
// ---------------------------------------------------------------------------
interface wb_arbiter_if;
  logic        stall;
  logic        flush;
  logic        mem_we1;
  logic [4:0]  mem_waddr1;
  logic [31:0] mem_wdata1;
  logic        mem_we2;
  logic [4:0]  mem_waddr2;
  logic [31:0] mem_wdata2;
  logic        lr_valid;
  logic [4:0]  lr_waddr;
  logic [31:0] lr_wdata;
  logic        lr_ready;
  logic        we1;
  logic [4:0]  waddr1;
  logic [31:0] wdata1;
  logic        we2;
  logic [4:0]  waddr2;
  logic [31:0] wdata2;
  logic [1:0]  lr_pending;

  modport slave (
    input  stall, flush,
    input  mem_we1, mem_waddr1, mem_wdata1,
    input  mem_we2, mem_waddr2, mem_wdata2,
    input  lr_valid, lr_waddr, lr_wdata,
    output lr_ready,
    output we1, waddr1, wdata1,
    output we2, waddr2, wdata2,
    output lr_pending
  );

  modport master (
    output stall, flush,
    output mem_we1, mem_waddr1, mem_wdata1,
    output mem_we2, mem_waddr2, mem_wdata2,
    output lr_valid, lr_waddr, lr_wdata,
    input  lr_ready,
    input  we1, waddr1, wdata1,
    input  we2, waddr2, wdata2,
    input  lr_pending
  );
endinterface

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
// Purpose : write-back stage arbiter. Registers the two in-order pipeline
//           slots and merges late results (held in a 2-entry in-order FIFO)
//           into whichever regfile write ports the slots leave idle.
// Ports   :
//   clk  - single clock, all state on posedge
//   rst  - asynchronous, active-low reset
//   bus  - wb_arbiter_if.slave (pipeline inputs, regfile outputs)
// Ordering: a late result is always older than the slot writes of the cycle
//           it would retire in, so any buffered/incoming late result whose
//           destination is overwritten by a live slot write is dropped.
// ---------------------------------------------------------------------------
module wb_arbiter (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);

  // Slot registers (MEM/WB boundary)
  logic        r_we1, r_we2;
  logic [4:0]  r_waddr1, r_waddr2;
  logic [31:0] r_wdata1, r_wdata2;

  // Late-result FIFO: entry 0 is always the oldest (shift-style compaction)
  logic [4:0]  r_buf_addr [2];
  logic [31:0] r_buf_data [2];
  logic [1:0]  r_count;

  logic        w_lr_ready;
  logic        w_accept;
  logic        w_drain1, w_drain2;
  logic        w_p2_idx;
  logic        w_p2_kill;
  logic        w_pop0, w_pop1;
  logic        w_s1_live, w_s2_live;
  logic [1:0]  w_hit;
  logic        w_hit_acc;
  logic        w_keep0, w_keep1, w_keep_acc;
  logic [4:0]  w_addr_next [2];
  logic [31:0] w_data_next [2];
  logic [1:0]  w_count_next;

  // -------------------------------------------------------------------------
  // Slot capture. flush and stall both insert a bubble, so their relative
  // priority is moot here; neither touches the late-result FIFO.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we1    <= 1'b0;
      r_waddr1 <= '0;
      r_wdata1 <= '0;
      r_we2    <= 1'b0;
      r_waddr2 <= '0;
      r_wdata2 <= '0;
    end else if (bus.flush || bus.stall) begin
      r_we1    <= 1'b0;
      r_waddr1 <= '0;
      r_wdata1 <= '0;
      r_we2    <= 1'b0;
      r_waddr2 <= '0;
      r_wdata2 <= '0;
    end else begin
      r_we1    <= bus.mem_we1;
      r_waddr1 <= bus.mem_waddr1;
      r_wdata1 <= bus.mem_wdata1;
      r_we2    <= bus.mem_we2;
      r_waddr2 <= bus.mem_waddr2;
      r_wdata2 <= bus.mem_wdata2;
    end
  end

  // Ready depends on registered occupancy only (no combinational path from lr_valid)
  assign w_lr_ready = (r_count != 2'd2);
  assign w_accept   = bus.lr_valid && w_lr_ready;

  // Drain selection: port 1 takes the head when slot 1 is idle; port 2 takes
  // the oldest entry port 1 did not take when slot 2 is idle.
  assign w_drain1 = !r_we1 && (r_count != 2'd0);
  assign w_drain2 = !r_we2 && (w_drain1 ? (r_count == 2'd2) : (r_count != 2'd0));
  assign w_p2_idx = w_drain1;

  // Writes to r0 are ignored by the regfile, so they never shadow a late result.
  assign w_s1_live = r_we1 && (r_waddr1 != 5'd0);
  assign w_s2_live = r_we2 && (r_waddr2 != 5'd0);

  // A head drained on port 2 beside a slot-1 write to the same register would
  // win by port priority and break age order, so it is consumed but not driven.
  assign w_p2_kill = w_drain2 && w_s1_live && (r_buf_addr[w_p2_idx] == r_waddr1);

  // Drained entries always form a prefix of the FIFO
  assign w_pop0 = w_drain1 || w_drain2;
  assign w_pop1 = w_drain1 && w_drain2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_hit
      assign w_hit[gi] = (w_s1_live && (r_buf_addr[gi] == r_waddr1)) ||
                         (w_s2_live && (r_buf_addr[gi] == r_waddr2));
    end
  endgenerate

  assign w_hit_acc = (w_s1_live && (bus.lr_waddr == r_waddr1)) ||
                     (w_s2_live && (bus.lr_waddr == r_waddr2));

  assign w_keep0    = (r_count != 2'd0) && !w_pop0 && !w_hit[0];
  assign w_keep1    = (r_count == 2'd2) && !w_pop1 && !w_hit[1];
  assign w_keep_acc = w_accept && (bus.lr_waddr != 5'd0) && !w_hit_acc;

  // Compact survivors (old entries first, then the accepted one). An accept
  // only happens below 2 entries, so at most two survivors exist.
  always_comb begin
    w_addr_next[0] = r_buf_addr[0];
    w_data_next[0] = r_buf_data[0];
    w_addr_next[1] = r_buf_addr[1];
    w_data_next[1] = r_buf_data[1];
    w_count_next   = {1'b0, w_keep0} + {1'b0, w_keep1} + {1'b0, w_keep_acc};
    if (w_keep0) begin
      if (!w_keep1) begin
        w_addr_next[1] = bus.lr_waddr;
        w_data_next[1] = bus.lr_wdata;
      end
    end else if (w_keep1) begin
      w_addr_next[0] = r_buf_addr[1];
      w_data_next[0] = r_buf_data[1];
      w_addr_next[1] = bus.lr_waddr;
      w_data_next[1] = bus.lr_wdata;
    end else begin
      w_addr_next[0] = bus.lr_waddr;
      w_data_next[0] = bus.lr_wdata;
    end
  end

  generate
    for (gi = 0; gi < 2; gi++) begin : g_buf
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_buf_addr[gi] <= '0;
          r_buf_data[gi] <= '0;
        end else begin
          r_buf_addr[gi] <= w_addr_next[gi];
          r_buf_data[gi] <= w_data_next[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_count <= 2'd0;
    else      r_count <= w_count_next;
  end

  // -------------------------------------------------------------------------
  // Regfile write ports, driven from registered state only.
  // -------------------------------------------------------------------------
  always_comb begin
    bus.we1    = 1'b0;
    bus.waddr1 = '0;
    bus.wdata1 = '0;
    bus.we2    = 1'b0;
    bus.waddr2 = '0;
    bus.wdata2 = '0;
    if (r_we1) begin
      bus.we1    = 1'b1;
      bus.waddr1 = r_waddr1;
      bus.wdata1 = r_wdata1;
    end else if (w_drain1) begin
      bus.we1    = 1'b1;
      bus.waddr1 = r_buf_addr[0];
      bus.wdata1 = r_buf_data[0];
    end
    if (r_we2) begin
      bus.we2    = 1'b1;
      bus.waddr2 = r_waddr2;
      bus.wdata2 = r_wdata2;
    end else if (w_drain2 && !w_p2_kill) begin
      bus.we2    = 1'b1;
      bus.waddr2 = r_buf_addr[w_p2_idx];
      bus.wdata2 = r_buf_data[w_p2_idx];
    end
  end

  assign bus.lr_ready   = w_lr_ready;
  assign bus.lr_pending = r_count;

endmodule

// File: tb/tb_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter
// Directed scenarios followed by randomized traffic. A queue-based reference
// model predicts each cycle's outputs; the stimulus process pushes them into
// a scoreboard and an independent monitor pops and compares them.
// ---------------------------------------------------------------------------
module tb_wb_arbiter;

  logic clk;
  logic rst;

  wb_arbiter_if bus();

  wb_arbiter u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        we2;
    logic [4:0]  a2;
    logic [31:0] d2;
    logic        rdy;
    logic [1:0]  pend;
  } exp_t;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  exp_t exp_q[$];

  // Reference model state: pending late results (oldest first) and slots
  ent_t        lq[$];
  logic        m_we   [2];
  logic [4:0]  m_addr [2];
  logic [31:0] m_data [2];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  function automatic logic slot_hit(input logic [4:0] a);
    for (int s = 0; s < 2; s++)
      if (m_we[s] && m_addr[s] != 5'd0 && m_addr[s] == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    lq.delete();
    for (int s = 0; s < 2; s++) begin
      m_we[s]   = 1'b0;
      m_addr[s] = '0;
      m_data[s] = '0;
    end
  endtask

  // One clock cycle: predict outputs from current model state, drive inputs,
  // then advance the model to the state after the coming posedge.
  task automatic cycle(input logic st, input logic fl,
                       input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic w2, input logic [4:0] a2, input logic [31:0] d2,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    exp_t e;
    int   used;
    logic acc;
    ent_t nq[$];
    ent_t ne;
    @(negedge clk);
    rst = 1'b1;
    cyc++;
    e = '0;
    used = 0;
    // Free ports take the oldest pending late results in order
    if (m_we[0]) begin
      e.we1 = 1'b1; e.a1 = m_addr[0]; e.d1 = m_data[0];
    end else if (lq.size() > used) begin
      e.we1 = 1'b1; e.a1 = lq[used].a; e.d1 = lq[used].d;
      used++;
    end
    if (m_we[1]) begin
      e.we2 = 1'b1; e.a2 = m_addr[1]; e.d2 = m_data[1];
    end else if (lq.size() > used) begin
      // An older result must not override the slot-1 write to the same register
      if (!(m_we[0] && m_addr[0] != 5'd0 && m_addr[0] == lq[used].a)) begin
        e.we2 = 1'b1; e.a2 = lq[used].a; e.d2 = lq[used].d;
      end
      used++;
    end
    e.rdy  = (lq.size() < 2);
    e.pend = 2'(lq.size());
    exp_q.push_back(e);

    bus.stall = st;      bus.flush = fl;
    bus.mem_we1 = w1;    bus.mem_waddr1 = a1;  bus.mem_wdata1 = d1;
    bus.mem_we2 = w2;    bus.mem_waddr2 = a2;  bus.mem_wdata2 = d2;
    bus.lr_valid = lv;   bus.lr_waddr = la;    bus.lr_wdata = ld;

    acc = lv && (lq.size() < 2);
    repeat (used) void'(lq.pop_front());
    foreach (lq[i]) if (!slot_hit(lq[i].a)) nq.push_back(lq[i]);
    if (acc && la != 5'd0 && !slot_hit(la)) begin
      ne.a = la; ne.d = ld;
      nq.push_back(ne);
    end
    lq = nq;
    if (st || fl) begin
      model_reset_slots();
    end else begin
      m_we[0] = w1; m_addr[0] = a1; m_data[0] = d1;
      m_we[1] = w2; m_addr[1] = a2; m_data[1] = d2;
    end
  endtask

  task automatic model_reset_slots();
    for (int s = 0; s < 2; s++) begin
      m_we[s] = 1'b0; m_addr[s] = '0; m_data[s] = '0;
    end
  endtask

  task automatic idle();
    cycle(0, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
  endtask

  // Reset asserted at a negedge and held for one full cycle
  task automatic do_reset();
    exp_t e;
    @(negedge clk);
    cyc++;
    rst = 1'b0;
    bus.stall = 0; bus.flush = 0;
    bus.mem_we1 = 0; bus.mem_waddr1 = 0; bus.mem_wdata1 = 0;
    bus.mem_we2 = 0; bus.mem_waddr2 = 0; bus.mem_wdata2 = 0;
    bus.lr_valid = 0; bus.lr_waddr = 0; bus.lr_wdata = 0;
    model_reset();
    e = '0;
    e.rdy = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end else begin
      $display("ok   %s cyc=%0d val=%h", name, cyc, act);
    end
  endtask

  // Scoreboard monitor: compares every presented output set against the model
  initial begin
    exp_t e;
    exp_t got;
    forever begin
      @(negedge clk);
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got.we1 = bus.we1; got.a1 = bus.waddr1; got.d1 = bus.wdata1;
        got.we2 = bus.we2; got.a2 = bus.waddr2; got.d2 = bus.wdata2;
        got.rdy = bus.lr_ready; got.pend = bus.lr_pending;
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL outputs cyc=%0d got we1=%0b a1=%0d d1=%h we2=%0b a2=%0d d2=%h rdy=%0b pend=%0d want we1=%0b a1=%0d d1=%h we2=%0b a2=%0d d2=%h rdy=%0b pend=%0d",
                   cyc, got.we1, got.a1, got.d1, got.we2, got.a2, got.d2, got.rdy, got.pend,
                   e.we1, e.a1, e.d1, e.we2, e.a2, e.d2, e.rdy, e.pend);
        end else begin
          $display("txn cyc=%0d we1=%0b a1=%0d we2=%0b a2=%0d rdy=%0b pend=%0d",
                   cyc, got.we1, got.a1, got.we2, got.a2, got.rdy, got.pend);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic st, fl, w1, w2, lv;
    logic [4:0] a1, a2, la;
    rst = 1'b0;
    bus.stall = 0; bus.flush = 0;
    bus.mem_we1 = 0; bus.mem_waddr1 = 0; bus.mem_wdata1 = 0;
    bus.mem_we2 = 0; bus.mem_waddr2 = 0; bus.mem_wdata2 = 0;
    bus.lr_valid = 0; bus.lr_waddr = 0; bus.lr_wdata = 0;
    model_reset();
    do_reset();
    #2;
    chk("reset_lr_ready", 32'(bus.lr_ready), 32'd1);
    chk("reset_pending", 32'(bus.lr_pending), 32'd0);

    // Slots busy for three cycles while a late result waits
    cycle(0, 0, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 1, 5'd7, 32'hDEAD);
    cycle(0, 0, 1, 5'd3, 32'h34, 1, 5'd4, 32'h45, 0, 5'd0, 32'd0);
    #2 chk("busy_pending", 32'(bus.lr_pending), 32'd1);
    cycle(0, 0, 1, 5'd3, 32'h35, 1, 5'd4, 32'h46, 0, 5'd0, 32'd0);
    idle();
    idle();
    #2;
    chk("drain_we1", 32'(bus.we1), 32'd1);
    chk("drain_waddr1", 32'(bus.waddr1), 32'd7);
    chk("drain_wdata1", bus.wdata1, 32'hDEAD);
    chk("drain_we2", 32'(bus.we2), 32'd0);

    // Two buffered entries drain together during a stall bubble
    cycle(0, 0, 1, 5'd11, 32'h11, 1, 5'd12, 32'h12, 1, 5'd5, 32'h55);
    cycle(1, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd6, 32'h66);
    cycle(1, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    #2;
    chk("dual_we1", 32'(bus.we1), 32'd1);
    chk("dual_we2", 32'(bus.we2), 32'd1);
    chk("dual_waddr1", 32'(bus.waddr1), 32'd5);
    chk("dual_waddr2", 32'(bus.waddr2), 32'd6);
    idle();
    #2 chk("dual_pending_after", 32'(bus.lr_pending), 32'd0);

    // Full buffer blocks accept; ready returns after a pop
    cycle(0, 0, 1, 5'd11, 32'h1, 1, 5'd12, 32'h2, 1, 5'd13, 32'hD13);
    cycle(0, 0, 1, 5'd11, 32'h3, 1, 5'd12, 32'h4, 1, 5'd14, 32'hD14);
    cycle(0, 0, 1, 5'd11, 32'h5, 1, 5'd12, 32'h6, 1, 5'd15, 32'hD15);
    #2;
    chk("full_lr_ready", 32'(bus.lr_ready), 32'd0);
    chk("full_pending", 32'(bus.lr_pending), 32'd2);
    cycle(0, 0, 1, 5'd11, 32'h7, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    idle();
    idle();
    #2 chk("after_pop_ready", 32'(bus.lr_ready), 32'd1);

    // Buffered entry shadowed by a slot write to the same register
    cycle(0, 0, 1, 5'd20, 32'h20, 1, 5'd21, 32'h21, 1, 5'd9, 32'hBAD9);
    cycle(0, 0, 1, 5'd9, 32'h1111, 1, 5'd10, 32'h2222, 0, 5'd0, 32'd0);
    idle();
    #2;
    chk("shadow_waddr1", 32'(bus.waddr1), 32'd9);
    chk("shadow_wdata1", bus.wdata1, 32'h1111);
    idle();
    #2;
    chk("shadow_pending", 32'(bus.lr_pending), 32'd0);
    chk("shadow_no_write", 32'(bus.we1), 32'd0);

    // Late result to r0 is accepted but never stored
    cycle(0, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd0, 32'hF00D);
    idle();
    #2;
    chk("r0_pending", 32'(bus.lr_pending), 32'd0);
    chk("r0_no_write", 32'(bus.we1), 32'd0);

    // Reset in the middle of activity
    cycle(0, 0, 1, 5'd1, 32'hA1, 1, 5'd2, 32'hA2, 1, 5'd3, 32'hA3);
    cycle(0, 0, 1, 5'd1, 32'hB1, 1, 5'd2, 32'hB2, 1, 5'd4, 32'hA4);
    cycle(0, 0, 1, 5'd1, 32'hC1, 1, 5'd2, 32'hC2, 0, 5'd0, 32'd0);
    do_reset();
    #2;
    chk("rst_we1", 32'(bus.we1), 32'd0);
    chk("rst_we2", 32'(bus.we2), 32'd0);
    chk("rst_ready", 32'(bus.lr_ready), 32'd1);
    chk("rst_pending", 32'(bus.lr_pending), 32'd0);
    idle();
    #2;
    chk("post_rst_we1", 32'(bus.we1), 32'd0);
    chk("post_rst_we2", 32'(bus.we2), 32'd0);

    // Randomized traffic with a small address space to provoke conflicts
    for (int n = 0; n < 1200; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        st = ($urandom_range(0, 7) == 0);
        fl = ($urandom_range(0, 15) == 0);
        w1 = $urandom_range(0, 1) == 1;
        w2 = $urandom_range(0, 1) == 1;
        lv = $urandom_range(0, 2) != 0;
        a1 = 5'($urandom_range(0, 7));
        a2 = 5'($urandom_range(0, 7));
        la = 5'($urandom_range(0, 7));
        cycle(st, fl, w1, a1, $urandom, w2, a2, $urandom, lv, la, $urandom);
      end
    end

    idle();
    @(negedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d leftover want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have these ports, one per line as name, direction, width, meaning (clock and reset first):
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  WB bubble request from pipeline control.
- flush  in  1  WB bubble request on exception/redirect.
- mem_we1  in  1  slot-1 write enable from MEM/WB boundary.
- mem_waddr1  in  5  slot-1 destination.
- mem_wdata1  in  32  slot-1 result.
- mem_we2, mem_waddr2, mem_wdata2  in  1/5/32  slot-2 equivalents; slot 2 is the younger instruction.
- lr_valid  in  1  late result offered (divider / miss load).
- lr_waddr  in  5  late result destination.
- lr_wdata  in  32  late result data.
- lr_ready  out  1  late-result buffer can accept.
- we1, waddr1, wdata1  out  1/5/32  regfile write port 1.
- we2, waddr2, wdata2  out  1/5/32  regfile write port 2; port 2 wins same-address conflicts.
- lr_pending  out  2  occupied late-result buffer entries (0..2).

Function
REQ-002 Slot registers: on posedge, if flush or stall, both slot write enables SHALL be loaded 0 (bubble); otherwise mem_we*/mem_waddr*/mem_wdata* SHALL be captured.
REQ-003 flush SHALL take precedence over stall; neither SHALL affect the late-result buffer.
REQ-004 Late-result buffer SHALL be a 2-entry in-order FIFO; lr_ready SHALL equal (lr_pending < 2), derived from registered state only.
REQ-005 Accept SHALL occur when lr_valid && lr_ready at posedge; an accepted entry with lr_waddr = 0 SHALL be discarded and SHALL NOT occupy an entry.
REQ-006 Port 1 SHALL carry slot 1 if its registered enable is set; otherwise port 1 SHALL carry the buffer head if present.
REQ-007 Port 2 SHALL carry slot 2 if its registered enable is set; otherwise port 2 SHALL carry the oldest buffer entry not already placed on port 1.
REQ-008 With both slots idle and 2 entries buffered, head SHALL go to port 1 and second entry to port 2 in the same cycle.
REQ-009 Drained entries SHALL be popped at the posedge ending the cycle they were driven; drain latency from accept SHALL be at least 1 cycle (no bypass from lr_* to ports).
REQ-010 Late results SHALL be older than any slot write in the same cycle: at posedge, any remaining buffered entry and any entry being accepted whose waddr equals an address written by a slot that cycle SHALL be discarded.
REQ-011 Slot writes with waddr = 0 SHALL be driven unchanged (regfile ignores them) and SHALL NOT trigger REQ-010 discards.
REQ-012 When both drained outputs in REQ-008 target the same address, the second entry (port 2) SHALL win per regfile priority; no extra logic is required.
REQ-013 Simultaneous accept and pop SHALL be allowed; lr_pending SHALL be updated as old − popped − discarded + accepted, never exceeding 2.
REQ-014 Unused ports SHALL drive we = 0, waddr = 0, wdata = 0.

Reset
REQ-015 While rst = 0, asynchronously: slot enables, addresses and data SHALL be 0; buffer empty; lr_pending = 0; lr_ready = 1; we1 = we2 = 0.
REQ-016 Reset asserted mid-drain SHALL drop all buffered entries; no write SHALL occur in the cycle after release unless newly captured.

Verification
REQ-017 Both slots busy (we1 = we2 = 1, addrs 3, 4) for 3 cycles, lr accepted (addr 7, 0xDEAD) -> lr held, lr_pending = 1, then drained on port 1 in the first bubble cycle.
REQ-018 stall = 1 with 2 entries buffered (addr 5, 6) -> same cycle we1 = we2 = 1, waddr1 = 5, waddr2 = 6; next cycle lr_pending = 0.
REQ-019 Buffer full, lr_valid = 1 -> lr_ready = 0, no accept; after one pop, lr_ready = 1 next cycle.
REQ-020 Buffered entry addr 9 while slot 1 writes addr 9 and slot 2 writes addr 10 -> entry discarded, lr_pending decrements, reg 9 holds slot-1 data.
REQ-021 lr_valid with lr_waddr = 0 -> accepted, lr_pending unchanged, no write issued.
REQ-022 rst low with 2 entries buffered and slots active -> all outputs 0 immediately, lr_ready = 1, no write after release.
